// File: rtl/shared_mul_arbiter_if.sv
// rtl/shared_mul_arbiter_if.sv - requester/result bundle for the shared multiplier arbiter
interface shared_mul_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 2
) ();
    logic                      hold;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*DATA_W-1:0]   a_in;
    logic [N_REQ*DATA_W-1:0]   b_in;
    logic [N_REQ-1:0]          gnt;
    logic                      res_valid;
    logic [TAG_W-1:0]          res_tag;
    logic [DATA_W-1:0]         res_data;
    logic                      busy;
    logic [15:0]               issue_cnt;

    modport master (
        output hold, req, a_in, b_in,
        input  gnt, res_valid, res_tag, res_data, busy, issue_cnt
    );

    modport slave (
        input  hold, req, a_in, b_in,
        output gnt, res_valid, res_tag, res_data, busy, issue_cnt
    );
endinterface

// File: rtl/shared_mul_arbiter.sv
// rtl/shared_mul_arbiter.sv - round-robin arbiter feeding one pipelined multiplier
module shared_mul_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int LAT    = 2,
    parameter int TAG_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    shared_mul_arbiter_if.slave bus
);
    logic [TAG_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  gnt_c;
    logic [TAG_W-1:0]  gnt_idx;
    logic              grant;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] prod_lo;
    logic [TAG_W-1:0]  mul_tag;
    logic              mul_v;
    logic              stage_busy;
    logic              res_valid_q;
    logic [TAG_W-1:0]  res_tag_q;
    logic [DATA_W-1:0] res_data_q;
    logic [15:0]       issue_cnt_q;

    // Scan from rr_ptr upward, wrapping modulo N_REQ; first set request wins.
    always_comb begin
        gnt_c   = '0;
        gnt_idx = '0;
        grant   = 1'b0;
        if (!rst && !bus.hold) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant && bus.req[(int'(rr_ptr) + k) % N_REQ]) begin
                    grant   = 1'b1;
                    gnt_idx = TAG_W'((int'(rr_ptr) + k) % N_REQ);
                    gnt_c[(int'(rr_ptr) + k) % N_REQ] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_a = bus.a_in[int'(gnt_idx)*DATA_W +: DATA_W];
        sel_b = bus.b_in[int'(gnt_idx)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            issue_cnt_q <= '0;
        end else if (grant) begin
            rr_ptr      <= (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
            issue_cnt_q <= issue_cnt_q + 16'd1;
        end
    end

    // Operands ride the pipe unmultiplied; the multiply sits in front of the result register.
    generate
        if (LAT == 1) begin : g_direct
            assign mul_a      = sel_a;
            assign mul_b      = sel_b;
            assign mul_tag    = gnt_idx;
            assign mul_v      = grant;
            assign stage_busy = 1'b0;
        end else begin : g_staged
            logic [LAT-2:0]             v_q;
            logic [LAT-2:0][TAG_W-1:0]  t_q;
            logic [LAT-2:0][DATA_W-1:0] a_q;
            logic [LAT-2:0][DATA_W-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= '0;
                    t_q <= '0;
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    v_q[0] <= grant;
                    if (grant) begin
                        t_q[0] <= gnt_idx;
                        a_q[0] <= sel_a;
                        b_q[0] <= sel_b;
                    end
                    for (int s = 1; s < LAT-1; s++) begin
                        v_q[s] <= v_q[s-1];
                        if (v_q[s-1]) begin
                            t_q[s] <= t_q[s-1];
                            a_q[s] <= a_q[s-1];
                            b_q[s] <= b_q[s-1];
                        end
                    end
                end
            end

            assign mul_a      = a_q[LAT-2];
            assign mul_b      = b_q[LAT-2];
            assign mul_tag    = t_q[LAT-2];
            assign mul_v      = v_q[LAT-2];
            assign stage_busy = |v_q;
        end
    endgenerate

    // Low half of the full product is identical to a DATA_W-wide multiply.
    assign prod_lo = mul_a * mul_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
        end else begin
            res_valid_q <= mul_v;
            if (mul_v) begin
                res_tag_q  <= mul_tag;
                res_data_q <= prod_lo;
            end
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_tag   = res_tag_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = res_valid_q | stage_busy;
    assign bus.issue_cnt = issue_cnt_q;
endmodule

// File: tb/tb_shared_mul_arbiter.sv
// tb/tb_shared_mul_arbiter.sv - scoreboard bench for shared_mul_arbiter
module tb_shared_mul_arbiter;
    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int TW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shared_mul_arbiter_if #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW)) bus_if ();

    shared_mul_arbiter #(.N_REQ(N), .DATA_W(DW), .LAT(LAT), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        int tag;
        int data;
        int due;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    int           m_ptr = 0;
    int           m_cnt = 0;
    logic [N-1:0] req_r;
    logic [DW-1:0] a_r[N];
    logic [DW-1:0] b_r[N];
    logic         hold_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic apply();
        bus_if.req  = req_r;
        bus_if.hold = hold_r;
        for (int i = 0; i < N; i++) begin
            bus_if.a_in[i*DW +: DW] = a_r[i];
            bus_if.b_in[i*DW +: DW] = b_r[i];
        end
    endtask

    // Reference arbitration: first asserted request at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] r, input logic h);
        if (h) return -1;
        for (int k = 0; k < N; k++)
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [DW-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic cycle(output int gi, output logic [N-1:0] g_seen);
        logic [N-1:0] exp_g;
        exp_t         e;
        longint       p;
        @(negedge clk);
        gi     = model_pick(req_r, hold_r);
        exp_g  = (gi < 0) ? '0 : N'(1 << gi);
        g_seen = bus_if.gnt;
        chk("gnt", 32'(bus_if.gnt), 32'(exp_g));
        chk("issue_cnt", 32'(bus_if.issue_cnt), m_cnt & 32'hFFFF);
        if (gi >= 0) begin
            p      = longint'(a_r[gi]) * longint'(b_r[gi]);
            e.tag  = gi;
            e.data = int'(p & 64'hFFFF);
            e.due  = cyc + LAT;
            sb.push_back(e);
            m_ptr = (gi + 1) % N;
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        m_ptr = 0;
        m_cnt = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sb.size() > 0; k++) @(posedge clk);
        #1;
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: busy from outstanding work, results popped in issue order with latency check.
    exp_t mon_e;
    always @(negedge clk) begin
        logic exp_busy;
        exp_busy = 1'b0;
        foreach (sb[i]) if (sb[i].due - LAT < cyc) exp_busy = 1'b1;
        chk("busy", 32'(bus_if.busy), 32'(exp_busy));
        if (sb.size() > 0 && sb[0].due < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL res_missing: tag %0d due cycle %0d not returned by cycle %0d", sb[0].tag, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (bus_if.res_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL res_unexpected: actual tag %0d data %0h required no result", bus_if.res_tag, bus_if.res_data);
            end else begin
                mon_e = sb.pop_front();
                chk("res_tag", 32'(bus_if.res_tag), 32'(mon_e.tag));
                chk("res_data", 32'(bus_if.res_data), 32'(mon_e.data));
                chk("res_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           gi;
        logic [N-1:0] g;
        logic [N-1:0] rr_exp[8];
        req_r  = '1;
        hold_r = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_r[i] = '0;
            b_r[i] = '0;
        end
        apply();
        @(negedge clk);
        chk("rst_gnt", 32'(bus_if.gnt), 32'd0);
        chk("rst_res_valid", 32'(bus_if.res_valid), 32'd0);
        chk("rst_res_tag", 32'(bus_if.res_tag), 32'd0);
        chk("rst_res_data", 32'(bus_if.res_data), 32'd0);
        chk("rst_issue_cnt", 32'(bus_if.issue_cnt), 32'd0);
        req_r = '0;
        apply();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single op
        req_r = 4'b0001; a_r[0] = 16'd3; b_r[0] = 16'd5; apply();
        cycle(gi, g);
        chk("single_gnt", 32'(g), 32'b0001);
        req_r = '0; apply();
        drain();

        // Round-robin from reset
        do_reset();
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < N; i++) begin
            a_r[i] = rand_op(); b_r[i] = rand_op();
        end
        req_r = '1; apply();
        for (int k = 0; k < 8; k++) begin
            cycle(gi, g);
            chk("rr_gnt", 32'(g), 32'(rr_exp[k]));
            if (gi >= 0) begin
                a_r[gi] = rand_op(); b_r[gi] = rand_op();
            end
            apply();
        end
        req_r = '0; apply();
        @(negedge clk);
        chk("rr_issue_cnt", 32'(bus_if.issue_cnt), 32'd8);
        @(posedge clk);
        #1;

        // Hold mid-stream
        req_r = '1; apply();
        cycle(gi, g);
        cycle(gi, g);
        hold_r = 1'b1; apply();
        for (int k = 0; k < 3; k++) begin
            cycle(gi, g);
            chk("hold_gnt", 32'(g), 32'd0);
        end
        hold_r = 1'b0; apply();
        cycle(gi, g);
        chk("hold_resume", 32'(g), 32'b0100);
        cycle(gi, g);
        chk("hold_resume2", 32'(g), 32'b1000);
        req_r = '0; apply();
        drain();

        // Pointer skip
        do_reset();
        req_r = 4'b0010; apply();
        cycle(gi, g);
        req_r = 4'b1001; apply();
        cycle(gi, g);
        chk("skip_gnt1", 32'(g), 32'b1000);
        cycle(gi, g);
        chk("skip_gnt2", 32'(g), 32'b0001);
        req_r = '0; apply();

        // Truncation
        req_r = 4'b0001; a_r[0] = 16'h0100; b_r[0] = 16'h0100; apply();
        cycle(gi, g);
        a_r[0] = 16'hFFFF; b_r[0] = 16'h0002; apply();
        cycle(gi, g);
        req_r = '0; apply();
        drain();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(gi, g);
            for (int i = 0; i < N; i++) begin
                if (!req_r[i] || i == gi) begin
                    req_r[i] = ($urandom_range(0, 3) != 0);
                    a_r[i]   = rand_op();
                    b_r[i]   = rand_op();
                end
            end
            hold_r = ($urandom_range(0, 9) == 0);
            apply();
        end
        req_r = '0; hold_r = 1'b0; apply();
        drain();

        // Reset mid-flight
        req_r = 4'b0001; a_r[0] = 16'h1234; b_r[0] = 16'h0007; apply();
        cycle(gi, g);
        rst = 1'b1;
        sb.delete();
        m_ptr = 0;
        m_cnt = 0;
        req_r = '1; apply();
        @(negedge clk);
        chk("mid_rst_gnt", 32'(bus_if.gnt), 32'd0);
        chk("mid_rst_res_valid", 32'(bus_if.res_valid), 32'd0);
        chk("mid_rst_res_tag", 32'(bus_if.res_tag), 32'd0);
        chk("mid_rst_res_data", 32'(bus_if.res_data), 32'd0);
        chk("mid_rst_issue_cnt", 32'(bus_if.issue_cnt), 32'd0);
        req_r = 4'b0100; a_r[2] = 16'h0009; b_r[2] = 16'h000B; apply();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(gi, g);
        chk("post_rst_gnt", 32'(g), 32'b0100);
        req_r = '0; apply();
        drain();
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
